// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared types for the register-file writeback scheduler.
// Word/address widths, source enum and the writeback request bundle.
package regfile_wb_scheduler_pkg;

    localparam int B_WORD = 32;
    localparam int N_REGS = 32;
    localparam int ADRS_W = 5;

    typedef logic [ADRS_W-1:0] adrs_t;
    typedef logic [B_WORD-1:0] word_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_t;

    typedef struct packed {
        adrs_t adrs;
        word_t data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Valid/ready writeback request channel.
// The master is the writeback source, the slave is the scheduler.
interface regfile_wb_scheduler_if;
    import regfile_wb_scheduler_pkg::*;

    logic  valid;
    logic  ready;
    adrs_t adrs;
    word_t data;

    modport master (
        output valid,
        output adrs,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  adrs,
        input  data,
        output ready
    );

endinterface

// File: rtl/regfile_wb_scheduler_wb_scoreboard.sv
// Pending-load scoreboard with read-hazard detection.
// A new issue wins over a same-cycle return to the same register.
module wb_scoreboard
    import regfile_wb_scheduler_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              set_i,
    input  adrs_t             set_adrs_i,
    input  logic              clr_i,
    input  adrs_t             clr_adrs_i,
    input  adrs_t             rd_a_i,
    input  adrs_t             rd_b_i,
    input  logic              wr_en_i,
    input  adrs_t             wr_adrs_i,
    input  adrs_t             lk_adrs_i,
    output logic [N_REGS-1:0] pending_o,
    output logic              hit_a_o,
    output logic              hit_b_o,
    output logic              lk_pend_o
);

    logic [N_REGS-1:0] pending_q;
    logic [N_REGS-1:0] pending_d;

    always_comb begin
        pending_d = pending_q;
        if (clr_i) begin
            pending_d[clr_adrs_i] = 1'b0;
        end
        if (set_i && (set_adrs_i != '0)) begin
            pending_d[set_adrs_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // A write on the port is not yet visible to a same-cycle read.
    assign hit_a_o = (rd_a_i != '0) &&
                     (pending_q[rd_a_i] ||
                      (wr_en_i && (wr_adrs_i == rd_a_i)));
    assign hit_b_o = (rd_b_i != '0) &&
                     (pending_q[rd_b_i] ||
                      (wr_en_i && (wr_adrs_i == rd_b_i)));

    assign lk_pend_o = pending_q[lk_adrs_i];
    assign pending_o = pending_q;

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates ALU and load-return writebacks onto the register file
// write port and raises the decode stall on pending registers.
module regfile_wb_scheduler
    import regfile_wb_scheduler_pkg::*;
(
    input  logic                    clk_cpu,
    input  logic                    reset_n,
    regfile_wb_scheduler_if.slave   alu,
    regfile_wb_scheduler_if.slave   mem,
    input  logic                    ld_issue,
    input  adrs_t                   ld_issue_adrs,
    input  adrs_t                   rd_adrs_a,
    input  adrs_t                   rd_adrs_b,
    output logic                    stall,
    output logic                    wr_en,
    output adrs_t                   wr_adrs,
    output word_t                   wr_data,
    output logic [N_REGS-1:0]       pending
);

    wb_src_t last_q, last_d;
    wb_req_t wr_q, wr_d;
    logic    wr_en_q, wr_en_d;

    logic alu_pend;
    logic alu_elig;
    logic mem_elig;
    logic gnt_alu;
    logic gnt_mem;
    logic hit_a;
    logic hit_b;

    wb_scoreboard u_sb (
        .clk_i      (clk_cpu),
        .rst_ni     (reset_n),
        .set_i      (ld_issue),
        .set_adrs_i (ld_issue_adrs),
        .clr_i      (gnt_mem),
        .clr_adrs_i (mem.adrs),
        .rd_a_i     (rd_adrs_a),
        .rd_b_i     (rd_adrs_b),
        .wr_en_i    (wr_en_q),
        .wr_adrs_i  (wr_q.adrs),
        .lk_adrs_i  (alu.adrs),
        .pending_o  (pending),
        .hit_a_o    (hit_a),
        .hit_b_o    (hit_b),
        .lk_pend_o  (alu_pend)
    );

    // ALU waits behind an outstanding load to the same register.
    assign alu_elig = alu.valid && !alu_pend;
    assign mem_elig = mem.valid;

    always_comb begin
        gnt_mem = 1'b0;
        gnt_alu = 1'b0;
        last_d  = last_q;
        wr_d    = wr_q;
        wr_en_d = 1'b0;
        if (reset_n) begin
            gnt_mem = mem_elig &&
                      (!alu_elig || (last_q == SRC_ALU));
            gnt_alu = alu_elig && !gnt_mem;
        end
        unique case (1'b1)
            gnt_mem: begin
                last_d  = SRC_MEM;
                wr_d    = '{adrs: mem.adrs, data: mem.data};
                wr_en_d = (mem.adrs != '0);
            end
            gnt_alu: begin
                last_d  = SRC_ALU;
                wr_d    = '{adrs: alu.adrs, data: alu.data};
                wr_en_d = (alu.adrs != '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_cpu) begin
        if (!reset_n) begin
            last_q  <= SRC_ALU;
            wr_q    <= '0;
            wr_en_q <= 1'b0;
        end else begin
            last_q  <= last_d;
            wr_q    <= wr_d;
            wr_en_q <= wr_en_d;
        end
    end

    assign alu.ready = gnt_alu;
    assign mem.ready = gnt_mem;
    assign stall     = !reset_n || hit_a || hit_b;
    assign wr_en     = wr_en_q;
    assign wr_adrs   = wr_q.adrs;
    assign wr_data   = wr_q.data;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler with a per-cycle model
// compare and hand-computed literal checkpoints.
module tb_regfile_wb_scheduler;

    logic        clk_cpu = 1'b0;
    logic        reset_n;
    logic        ld_issue;
    logic [4:0]  ld_issue_adrs;
    logic [4:0]  rd_adrs_a;
    logic [4:0]  rd_adrs_b;
    logic        stall;
    logic        wr_en;
    logic [4:0]  wr_adrs;
    logic [31:0] wr_data;
    logic [31:0] pending;

    int checks   = 0;
    int failures = 0;

    regfile_wb_scheduler_if alu_if ();
    regfile_wb_scheduler_if mem_if ();

    regfile_wb_scheduler dut (
        .clk_cpu       (clk_cpu),
        .reset_n       (reset_n),
        .alu           (alu_if.slave),
        .mem           (mem_if.slave),
        .ld_issue      (ld_issue),
        .ld_issue_adrs (ld_issue_adrs),
        .rd_adrs_a     (rd_adrs_a),
        .rd_adrs_b     (rd_adrs_b),
        .stall         (stall),
        .wr_en         (wr_en),
        .wr_adrs       (wr_adrs),
        .wr_data       (wr_data),
        .pending       (pending)
    );

    always #5 clk_cpu = ~clk_cpu;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Behavioural model: register state as seen after the last edge.
    bit        m_known = 0;
    bit [31:0] m_pend;
    bit        m_last_mem;
    bit        m_wr_en;
    bit [4:0]  m_wr_adrs;
    bit [31:0] m_wr_data;

    function automatic bit m_hit(input bit [4:0] x);
        if (x == 0) return 1'b0;
        if (m_pend[x]) return 1'b1;
        return m_wr_en && (m_wr_adrs == x);
    endfunction

    always @(negedge clk_cpu) begin
        bit ae, me, take_mem, take_alu;
        if (!reset_n) begin
            chk("m_rst_alu_ready", {31'b0, alu_if.ready}, 0);
            chk("m_rst_mem_ready", {31'b0, mem_if.ready}, 0);
            chk("m_rst_stall", {31'b0, stall}, 1);
            m_known    = 1;
            m_pend     = '0;
            m_last_mem = 0;
            m_wr_en    = 0;
            m_wr_adrs  = '0;
            m_wr_data  = '0;
        end else if (m_known) begin
            ae = alu_if.valid && !m_pend[alu_if.adrs];
            me = mem_if.valid;
            if (ae && me) begin
                take_mem = !m_last_mem;
                take_alu = m_last_mem;
            end else begin
                take_mem = me;
                take_alu = ae;
            end
            chk("m_alu_ready", {31'b0, alu_if.ready}, {31'b0, take_alu});
            chk("m_mem_ready", {31'b0, mem_if.ready}, {31'b0, take_mem});
            chk("m_stall", {31'b0, stall},
                {31'b0, m_hit(rd_adrs_a) || m_hit(rd_adrs_b)});
            chk("m_wr_en", {31'b0, wr_en}, {31'b0, m_wr_en});
            chk("m_wr_adrs", {27'b0, wr_adrs}, {27'b0, m_wr_adrs});
            chk("m_wr_data", wr_data, m_wr_data);
            chk("m_pending", pending, m_pend);
            m_wr_en = 0;
            if (take_mem) begin
                m_wr_en    = mem_if.adrs != 0;
                m_wr_adrs  = mem_if.adrs;
                m_wr_data  = mem_if.data;
                m_last_mem = 1;
                m_pend[mem_if.adrs] = 0;
            end else if (take_alu) begin
                m_wr_en    = alu_if.adrs != 0;
                m_wr_adrs  = alu_if.adrs;
                m_wr_data  = alu_if.data;
                m_last_mem = 0;
            end
            if (ld_issue && ld_issue_adrs != 0) m_pend[ld_issue_adrs] = 1;
        end
    end

    task automatic tick();
        @(posedge clk_cpu);
        #1;
    endtask

    task automatic src(input bit av, input bit [4:0] aa, input bit [31:0] ad,
                       input bit mv, input bit [4:0] ma, input bit [31:0] md);
        alu_if.valid = av;
        alu_if.adrs  = aa;
        alu_if.data  = ad;
        mem_if.valid = mv;
        mem_if.adrs  = ma;
        mem_if.data  = md;
    endtask

    initial begin
        reset_n       = 1'b0;
        ld_issue      = 1'b0;
        ld_issue_adrs = '0;
        rd_adrs_a     = '0;
        rd_adrs_b     = '0;
        src(1, 1, 32'h11, 1, 2, 32'h22);
        repeat (2) begin
            @(negedge clk_cpu);
            chk("rst_alu_ready", {31'b0, alu_if.ready}, 0);
            chk("rst_mem_ready", {31'b0, mem_if.ready}, 0);
            chk("rst_stall", {31'b0, stall}, 1);
            tick();
        end
        reset_n = 1'b1;
        src(0, 0, 0, 0, 0, 0);
        @(negedge clk_cpu);
        chk("post_rst_wr_en", {31'b0, wr_en}, 0);
        chk("post_rst_pending", pending, 0);
        chk("post_rst_stall", {31'b0, stall}, 0);
        tick();

        src(1, 3, 32'hDEADBEEF, 0, 0, 0);
        @(negedge clk_cpu);
        chk("alu_ready_same_cycle", {31'b0, alu_if.ready}, 1);
        tick();
        src(0, 0, 0, 0, 0, 0);
        rd_adrs_a = 5'd3;
        @(negedge clk_cpu);
        chk("alu_wr_en", {31'b0, wr_en}, 1);
        chk("alu_wr_adrs", {27'b0, wr_adrs}, 3);
        chk("alu_wr_data", wr_data, 32'hDEADBEEF);
        chk("alu_inflight_stall", {31'b0, stall}, 1);
        tick();
        @(negedge clk_cpu);
        chk("alu_after_stall", {31'b0, stall}, 0);
        chk("alu_after_wr_en", {31'b0, wr_en}, 0);
        tick();
        rd_adrs_a = '0;

        for (int i = 0; i < 4; i++) begin
            src(1, 5'(10 + i), 32'hA000 + i, 1, 5'(20 + i), 32'hB000 + i);
            @(negedge clk_cpu);
            chk("rr_mem_ready", {31'b0, mem_if.ready}, (i % 2 == 0) ? 1 : 0);
            chk("rr_alu_ready", {31'b0, alu_if.ready}, (i % 2 == 0) ? 0 : 1);
            tick();
        end

        src(0, 0, 0, 0, 0, 0);
        ld_issue      = 1'b1;
        ld_issue_adrs = 5'd7;
        @(negedge clk_cpu);
        tick();
        ld_issue  = 1'b0;
        rd_adrs_b = 5'd7;
        src(1, 7, 32'hA7, 1, 7, 32'h55);
        @(negedge clk_cpu);
        chk("ld_pending7", {31'b0, pending[7]}, 1);
        chk("ld_stall_b", {31'b0, stall}, 1);
        chk("ld_alu_blocked", {31'b0, alu_if.ready}, 0);
        chk("ld_mem_granted", {31'b0, mem_if.ready}, 1);
        tick();
        src(1, 7, 32'hA7, 0, 0, 0);
        @(negedge clk_cpu);
        chk("ld_pending7_clr", {31'b0, pending[7]}, 0);
        chk("ld_wr_data", wr_data, 32'h55);
        chk("ld_wr_adrs", {27'b0, wr_adrs}, 7);
        chk("ld_alu_after", {31'b0, alu_if.ready}, 1);
        tick();
        src(0, 0, 0, 0, 0, 0);
        rd_adrs_b = '0;
        @(negedge clk_cpu);
        chk("ld_alu_wr_data", wr_data, 32'hA7);
        tick();

        src(0, 0, 0, 1, 9, 32'h99);
        ld_issue      = 1'b1;
        ld_issue_adrs = 5'd9;
        @(negedge clk_cpu);
        chk("sc_mem_ready", {31'b0, mem_if.ready}, 1);
        tick();
        src(0, 0, 0, 0, 0, 0);
        ld_issue = 1'b0;
        @(negedge clk_cpu);
        chk("sc_pending9", {31'b0, pending[9]}, 1);
        chk("sc_wr_en", {31'b0, wr_en}, 1);
        chk("sc_wr_data", wr_data, 32'h99);
        tick();
        src(0, 0, 0, 1, 9, 32'h1234);
        @(negedge clk_cpu);
        tick();
        src(0, 0, 0, 0, 0, 0);
        @(negedge clk_cpu);
        chk("sc_pending9_clr", {31'b0, pending[9]}, 0);
        tick();

        src(1, 0, 32'hFFFF, 0, 0, 0);
        ld_issue      = 1'b1;
        ld_issue_adrs = 5'd0;
        rd_adrs_a     = 5'd0;
        @(negedge clk_cpu);
        chk("r0_alu_ready", {31'b0, alu_if.ready}, 1);
        chk("r0_stall", {31'b0, stall}, 0);
        tick();
        src(0, 0, 0, 0, 0, 0);
        ld_issue = 1'b0;
        @(negedge clk_cpu);
        chk("r0_wr_en", {31'b0, wr_en}, 0);
        chk("r0_pending", pending, 0);
        chk("r0_stall_after", {31'b0, stall}, 0);
        tick();

        src(1, 6, 32'h66, 0, 0, 0);
        ld_issue      = 1'b1;
        ld_issue_adrs = 5'd5;
        @(negedge clk_cpu);
        tick();
        ld_issue = 1'b0;
        reset_n  = 1'b0;
        src(1, 11, 32'hC1, 1, 12, 32'hC2);
        @(negedge clk_cpu);
        chk("mid_pending5", {31'b0, pending[5]}, 1);
        chk("mid_wr_en", {31'b0, wr_en}, 1);
        chk("mid_rst_stall", {31'b0, stall}, 1);
        tick();
        reset_n = 1'b1;
        @(negedge clk_cpu);
        chk("mid_pending_clr", pending, 0);
        chk("mid_wr_en_drop", {31'b0, wr_en}, 0);
        chk("mid_mem_first", {31'b0, mem_if.ready}, 1);
        chk("mid_alu_wait", {31'b0, alu_if.ready}, 0);
        tick();
        src(0, 0, 0, 0, 0, 0);
        @(negedge clk_cpu);
        chk("mid_wr_adrs", {27'b0, wr_adrs}, 12);
        chk("mid_wr_data", wr_data, 32'hC2);
        tick();
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
